// File: rtl/router_pkg.sv
// Shared router types: flit format, node address and the ejection packet states.
// Every router-side block imports this package.
package router_pkg;

    localparam int LOCAL = 4;

    typedef enum logic [1:0] {
        HEAD   = 2'd0,
        BODY   = 2'd1,
        TAIL   = 2'd2,
        SINGLE = 2'd3
    } flit_type_t;

    typedef struct packed {
        logic [3:0] xaddr;
        logic [3:0] yaddr;
    } router_conf_t;

    typedef struct packed {
        flit_type_t flit_type;
        logic [3:0] dst_x;
        logic [3:0] dst_y;
        logic [31:0] payload;
    } FLIT_t;

    typedef enum logic {
        EJ_IDLE   = 1'b0,
        EJ_IN_PKT = 1'b1
    } eject_state_t;

    // Packet length counter that sticks at 255.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/flit_fifo.sv
// Flit buffer with wrap-bit pointers; also meant for router input buffers.
// Read is combinational so a flit can be consumed the cycle after it is written.
module flit_fifo
    import router_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    localparam int AW = $clog2(FIFO_DEPTH)
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        push,
    input  logic        pop,
    input  FLIT_t       wr_data,
    output FLIT_t       rd_data,
    output logic [AW:0] count,
    output logic        full,
    output logic        empty
);

    FLIT_t       mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    logic        push_ok;
    logic        pop_ok;

    assign count = wr_ptr_reg - rd_ptr_reg;
    assign full  = (count == (AW+1)'(FIFO_DEPTH));
    assign empty = (wr_ptr_reg == rd_ptr_reg);

    // A pop in the same cycle frees a slot, so a push into a full buffer still lands.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    assign rd_data = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

endmodule

// File: rtl/local_eject_unit.sv
// Ejection interface on a router LOCAL port: buffers flits, drains them at a
// programmable rate, returns on/off flow control and checks packet framing.
module local_eject_unit
    import router_pkg::*;
#(
    parameter router_conf_t router_conf = '{xaddr: 4'd0, yaddr: 4'd0},
    parameter int FIFO_DEPTH   = 8,
    parameter int OFF_THRESH   = FIFO_DEPTH - 2,
    parameter int ON_THRESH    = 2,
    parameter int DRAIN_PERIOD = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  FLIT_t       i_flit,
    input  logic        i_upstream_req,
    output logic        o_on_off,
    output logic        o_pkt_done,
    output logic [7:0]  o_pkt_len,
    output logic [31:0] o_flit_count,
    output logic [15:0] o_pkt_count,
    output logic        o_err_overflow,
    output logic        o_err_proto,
    output logic        o_err_misroute
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = (DRAIN_PERIOD > 1) ? $clog2(DRAIN_PERIOD) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_PERIOD - 1);

    FLIT_t        pop_flit;
    logic [AW:0]  fifo_count;
    logic         fifo_full;
    logic         fifo_empty;
    logic         pop_en;
    logic         push_ok;
    logic         overflow_evt;
    logic [AW:0]  occ_next;
    logic         dst_mismatch;
    logic         unused_payload;

    logic [DW-1:0] drain_cnt_reg;
    logic          on_off_reg;
    eject_state_t  state_reg;
    logic [7:0]    len_reg;
    logic          pkt_done_reg;
    logic [7:0]    pkt_len_reg;
    logic [15:0]   pkt_count_reg;
    logic [31:0]   flit_count_reg;
    logic          err_overflow_reg;
    logic          err_proto_reg;
    logic          err_misroute_reg;

    flit_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (i_upstream_req),
        .pop     (pop_en),
        .wr_data (i_flit),
        .rd_data (pop_flit),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign pop_en       = (drain_cnt_reg == DRAIN_LAST) && !fifo_empty;
    assign push_ok      = i_upstream_req && (!fifo_full || pop_en);
    assign overflow_evt = i_upstream_req && !push_ok;
    assign occ_next     = fifo_count + (AW+1)'(push_ok) - (AW+1)'(pop_en);
    assign dst_mismatch = (pop_flit.dst_x != router_conf.xaddr) ||
                          (pop_flit.dst_y != router_conf.yaddr);
    assign unused_payload = ^pop_flit.payload;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            drain_cnt_reg <= '0;
        end else if (drain_cnt_reg == DRAIN_LAST) begin
            drain_cnt_reg <= '0;
        end else begin
            drain_cnt_reg <= drain_cnt_reg + 1'b1;
        end
    end

    // Hysteresis: between the thresholds the previous decision holds.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            on_off_reg <= 1'b1;
        end else if (occ_next >= (AW+1)'(OFF_THRESH)) begin
            on_off_reg <= 1'b0;
        end else if (occ_next <= (AW+1)'(ON_THRESH)) begin
            on_off_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg        <= EJ_IDLE;
            len_reg          <= '0;
            pkt_done_reg     <= 1'b0;
            pkt_len_reg      <= '0;
            pkt_count_reg    <= '0;
            flit_count_reg   <= '0;
            err_overflow_reg <= 1'b0;
            err_proto_reg    <= 1'b0;
            err_misroute_reg <= 1'b0;
        end else begin
            pkt_done_reg <= 1'b0;
            if (overflow_evt) err_overflow_reg <= 1'b1;
            if (pop_en) begin
                flit_count_reg <= flit_count_reg + 32'd1;
                if ((pop_flit.flit_type == HEAD || pop_flit.flit_type == SINGLE) && dst_mismatch) begin
                    err_misroute_reg <= 1'b1;
                end
                case (state_reg)
                    EJ_IDLE: begin
                        case (pop_flit.flit_type)
                            HEAD: begin
                                len_reg   <= 8'd1;
                                state_reg <= EJ_IN_PKT;
                            end
                            SINGLE: begin
                                pkt_done_reg  <= 1'b1;
                                pkt_len_reg   <= 8'd1;
                                pkt_count_reg <= pkt_count_reg + 16'd1;
                            end
                            default: err_proto_reg <= 1'b1;
                        endcase
                    end
                    default: begin
                        case (pop_flit.flit_type)
                            BODY: len_reg <= sat_inc(len_reg);
                            TAIL: begin
                                pkt_done_reg  <= 1'b1;
                                pkt_len_reg   <= sat_inc(len_reg);
                                pkt_count_reg <= pkt_count_reg + 16'd1;
                                state_reg     <= EJ_IDLE;
                            end
                            HEAD: begin
                                // Abandon the open packet and start over from this HEAD.
                                err_proto_reg <= 1'b1;
                                len_reg       <= 8'd1;
                            end
                            default: begin
                                err_proto_reg <= 1'b1;
                                pkt_done_reg  <= 1'b1;
                                pkt_len_reg   <= 8'd1;
                                pkt_count_reg <= pkt_count_reg + 16'd1;
                                state_reg     <= EJ_IDLE;
                            end
                        endcase
                    end
                endcase
            end
        end
    end

    assign o_on_off       = on_off_reg;
    assign o_pkt_done     = pkt_done_reg;
    assign o_pkt_len      = pkt_len_reg;
    assign o_flit_count   = flit_count_reg;
    assign o_pkt_count    = pkt_count_reg;
    assign o_err_overflow = err_overflow_reg;
    assign o_err_proto    = err_proto_reg;
    assign o_err_misroute = err_misroute_reg;

endmodule

// File: tb/tb_local_eject_unit.sv
// Directed bench for local_eject_unit: three instances with drain periods 1, 4
// and 1000 share clock, reset and flit bus; each scenario drives one of them.
module tb_local_eject_unit;
    import router_pkg::*;

    logic  clk = 1'b0;
    logic  reset_n = 1'b0;
    FLIT_t flit;
    logic  req1 = 1'b0, req4 = 1'b0, reqs = 1'b0;

    logic        on1, done1, ov1, pr1, mr1;
    logic [7:0]  len1;
    logic [31:0] fc1;
    logic [15:0] pc1;
    logic        on4, done4, ov4, pr4, mr4;
    logic [7:0]  len4;
    logic [31:0] fc4;
    logic [15:0] pc4;
    logic        ons, dones, ovs, prs, mrs;
    logic [7:0]  lens;
    logic [31:0] fcs;
    logic [15:0] pcs;

    int checks = 0;
    int errors = 0;
    int done1_cnt = 0, dones_cnt = 0, off1_cnt = 0;

    always #5 clk = ~clk;

    local_eject_unit #(.DRAIN_PERIOD(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .i_flit(flit), .i_upstream_req(req1),
        .o_on_off(on1), .o_pkt_done(done1), .o_pkt_len(len1), .o_flit_count(fc1),
        .o_pkt_count(pc1), .o_err_overflow(ov1), .o_err_proto(pr1), .o_err_misroute(mr1));

    local_eject_unit #(.DRAIN_PERIOD(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .i_flit(flit), .i_upstream_req(req4),
        .o_on_off(on4), .o_pkt_done(done4), .o_pkt_len(len4), .o_flit_count(fc4),
        .o_pkt_count(pc4), .o_err_overflow(ov4), .o_err_proto(pr4), .o_err_misroute(mr4));

    local_eject_unit #(.DRAIN_PERIOD(1000)) dut_slow (
        .clk(clk), .reset_n(reset_n), .i_flit(flit), .i_upstream_req(reqs),
        .o_on_off(ons), .o_pkt_done(dones), .o_pkt_len(lens), .o_flit_count(fcs),
        .o_pkt_count(pcs), .o_err_overflow(ovs), .o_err_proto(prs), .o_err_misroute(mrs));

    always @(posedge clk) begin
        if (done1) done1_cnt++;
        if (dones) dones_cnt++;
        if (!on1)  off1_cnt++;
    end

    function automatic FLIT_t mk(input flit_type_t t, input logic [3:0] x, input logic [3:0] y,
                                 input logic [31:0] p);
        FLIT_t f;
        f.flit_type = t;
        f.dst_x     = x;
        f.dst_y     = y;
        f.payload   = p;
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req1 = 1'b0; req4 = 1'b0; reqs = 1'b0;
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
    endtask

    // which: 1 -> dut1, 4 -> dut4, 0 -> dut_slow
    task automatic push(input int which, input FLIT_t f);
        flit = f;
        req1 = (which == 1); req4 = (which == 4); reqs = (which == 0);
        tick();
        req1 = 1'b0; req4 = 1'b0; reqs = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({on1, on4, ons} !== 3'b111) begin errors++; $display("FAIL reset_on_off: got %b want 111", {on1, on4, ons}); end
        checks++; if ({done1, ov1, pr1, mr1, dones, ovs, prs, mrs} !== 8'h00) begin errors++; $display("FAIL reset_flags: got %b want 00000000", {done1, ov1, pr1, mr1, dones, ovs, prs, mrs}); end
        checks++; if ({fc1, pc1, len1} !== 56'd0) begin errors++; $display("FAIL reset_counters: fc=%0d pc=%0d len=%0d want 0", fc1, pc1, len1); end
        $display("test_reset: on_off=%b fc=%0d pc=%0d", on1, fc1, pc1);
    endtask

    task automatic test_basic_packet();
        int d0, o0;
        do_reset();
        d0 = done1_cnt; o0 = off1_cnt;
        push(1, mk(HEAD, 4'd0, 4'd0, 32'h11));
        push(1, mk(BODY, 4'd0, 4'd0, 32'h22));
        push(1, mk(BODY, 4'd0, 4'd0, 32'h33));
        push(1, mk(TAIL, 4'd0, 4'd0, 32'h44));
        repeat (5) tick();
        checks++; if (done1_cnt - d0 !== 1) begin errors++; $display("FAIL basic_done_pulses: got %0d want 1", done1_cnt - d0); end
        checks++; if (len1 !== 8'd4) begin errors++; $display("FAIL basic_pkt_len: got %0d want 4", len1); end
        checks++; if (pc1 !== 16'd1) begin errors++; $display("FAIL basic_pkt_count: got %0d want 1", pc1); end
        checks++; if (fc1 !== 32'd4) begin errors++; $display("FAIL basic_flit_count: got %0d want 4", fc1); end
        checks++; if ({ov1, pr1, mr1} !== 3'b000) begin errors++; $display("FAIL basic_errors: got %b want 000", {ov1, pr1, mr1}); end
        checks++; if (off1_cnt - o0 !== 0) begin errors++; $display("FAIL basic_on_off: dropped %0d cycles want 0", off1_cnt - o0); end
        $display("test_basic_packet: len=%0d pc=%0d fc=%0d", len1, pc1, fc1);
    endtask

    task automatic test_flow_control();
        int fall_edge = 0, rise_edge = 0, pushes = 0, pushes_at_fall = 0;
        logic prev_on;
        do_reset();
        prev_on = on4;
        for (int k = 1; k <= 40; k++) begin
            flit = mk(BODY, 4'd0, 4'd0, 32'(k));
            req4 = on4;
            if (on4) pushes++;
            tick();
            if (prev_on && !on4 && fall_edge == 0) begin fall_edge = k; pushes_at_fall = pushes; end
            if (!prev_on && on4 && fall_edge != 0 && rise_edge == 0) rise_edge = k;
            prev_on = on4;
        end
        req4 = 1'b0;
        // Pops at edges 4,8,12...: occupancy hits 6 at edge 7, falls back to 2 at edge 20.
        checks++; if (fall_edge !== 7) begin errors++; $display("FAIL fc_fall_edge: got %0d want 7", fall_edge); end
        checks++; if (pushes_at_fall !== 7) begin errors++; $display("FAIL fc_pushes_at_fall: got %0d want 7", pushes_at_fall); end
        checks++; if (rise_edge !== 20) begin errors++; $display("FAIL fc_rise_edge: got %0d want 20", rise_edge); end
        checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL fc_overflow: got %b want 0", ov4); end
        $display("test_flow_control: fall=%0d rise=%0d pushes=%0d", fall_edge, rise_edge, pushes);
    endtask

    task automatic test_overflow();
        int d0;
        do_reset();
        d0 = dones_cnt;
        push(0, mk(HEAD, 4'd0, 4'd0, 32'h1));
        for (int i = 2; i <= 7; i++) push(0, mk(BODY, 4'd0, 4'd0, 32'(i)));
        checks++; if (ons !== 1'b0) begin errors++; $display("FAIL ovf_on_off_low: got %b want 0", ons); end
        push(0, mk(TAIL, 4'd0, 4'd0, 32'h8));
        checks++; if (ovs !== 1'b0) begin errors++; $display("FAIL ovf_before_full: got %b want 0", ovs); end
        push(0, mk(SINGLE, 4'd2, 4'd3, 32'h9));
        checks++; if (ovs !== 1'b1) begin errors++; $display("FAIL ovf_flit9: got %b want 1", ovs); end
        push(0, mk(SINGLE, 4'd2, 4'd3, 32'hA));
        repeat (8100) tick();
        checks++; if (dones_cnt - d0 !== 1) begin errors++; $display("FAIL ovf_done_pulses: got %0d want 1", dones_cnt - d0); end
        checks++; if (lens !== 8'd8) begin errors++; $display("FAIL ovf_pkt_len: got %0d want 8", lens); end
        checks++; if (fcs !== 32'd8) begin errors++; $display("FAIL ovf_flit_count: got %0d want 8", fcs); end
        checks++; if ({prs, mrs} !== 2'b00) begin errors++; $display("FAIL ovf_dropped_seen: proto/misroute got %b want 00", {prs, mrs}); end
        $display("test_overflow: ovf=%b len=%0d fc=%0d", ovs, lens, fcs);
    endtask

    task automatic test_misroute();
        do_reset();
        push(1, mk(HEAD, 4'd1, 4'd0, 32'h5));
        push(1, mk(TAIL, 4'd1, 4'd0, 32'h6));
        repeat (3) tick();
        checks++; if (mr1 !== 1'b1) begin errors++; $display("FAIL misroute_flag: got %b want 1", mr1); end
        checks++; if (pc1 !== 16'd1) begin errors++; $display("FAIL misroute_pkt_count: got %0d want 1", pc1); end
        checks++; if (len1 !== 8'd2) begin errors++; $display("FAIL misroute_pkt_len: got %0d want 2", len1); end
        checks++; if (pr1 !== 1'b0) begin errors++; $display("FAIL misroute_proto: got %b want 0", pr1); end
        $display("test_misroute: misroute=%b pc=%0d len=%0d", mr1, pc1, len1);
    endtask

    task automatic test_protocol();
        int d0;
        do_reset();
        d0 = done1_cnt;
        push(1, mk(BODY, 4'd0, 4'd0, 32'h1));
        repeat (2) tick();
        checks++; if (pr1 !== 1'b1) begin errors++; $display("FAIL proto_body_idle: got %b want 1", pr1); end
        push(1, mk(HEAD, 4'd0, 4'd0, 32'h2));
        push(1, mk(HEAD, 4'd0, 4'd0, 32'h3));
        push(1, mk(TAIL, 4'd0, 4'd0, 32'h4));
        repeat (3) tick();
        checks++; if (pc1 !== 16'd1) begin errors++; $display("FAIL proto_pkt_count: got %0d want 1", pc1); end
        checks++; if (len1 !== 8'd2) begin errors++; $display("FAIL proto_pkt_len: got %0d want 2", len1); end
        checks++; if (fc1 !== 32'd4) begin errors++; $display("FAIL proto_flit_count: got %0d want 4", fc1); end
        checks++; if (done1_cnt - d0 !== 1) begin errors++; $display("FAIL proto_done_pulses: got %0d want 1", done1_cnt - d0); end
        $display("test_protocol: proto=%b pc=%0d len=%0d", pr1, pc1, len1);
    endtask

    task automatic test_reset_mid_packet();
        int d0, waited;
        do_reset();
        push(0, mk(HEAD, 4'd0, 4'd0, 32'h1));
        for (int i = 0; i < 8; i++) push(0, mk(BODY, 4'd0, 4'd0, 32'(i)));
        checks++; if ({ovs, ons} !== 2'b10) begin errors++; $display("FAIL mid_pre_state: ovf/on got %b want 10", {ovs, ons}); end
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        checks++; if (ons !== 1'b1) begin errors++; $display("FAIL mid_on_off: got %b want 1", ons); end
        checks++; if ({ovs, prs, mrs} !== 3'b000) begin errors++; $display("FAIL mid_flags: got %b want 000", {ovs, prs, mrs}); end
        checks++; if ({fcs, pcs, lens} !== 56'd0) begin errors++; $display("FAIL mid_counters: fc=%0d pc=%0d len=%0d want 0", fcs, pcs, lens); end
        // A lone TAIL must be the first flit out and hit an IDLE FSM.
        d0 = dones_cnt;
        push(0, mk(TAIL, 4'd0, 4'd0, 32'h7));
        waited = 0;
        while (fcs == 32'd0 && waited < 1200) begin tick(); waited++; end
        tick();
        checks++; if (fcs !== 32'd1) begin errors++; $display("FAIL mid_drain_timeout: fc got %0d want 1", fcs); end
        checks++; if (prs !== 1'b1) begin errors++; $display("FAIL mid_tail_proto: got %b want 1", prs); end
        checks++; if (pcs !== 16'd0) begin errors++; $display("FAIL mid_pkt_count: got %0d want 0", pcs); end
        checks++; if (dones_cnt - d0 !== 0) begin errors++; $display("FAIL mid_done_pulses: got %0d want 0", dones_cnt - d0); end
        $display("test_reset_mid_packet: proto=%b fc=%0d pc=%0d", prs, fcs, pcs);
    endtask

    initial begin
        flit = mk(HEAD, 4'd0, 4'd0, 32'h0);
        test_reset();
        test_basic_packet();
        test_flow_control();
        test_overflow();
        test_misroute();
        test_protocol();
        test_reset_mid_packet();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/local_eject_unit.md
# local_eject_unit

Ejection-side network interface for one router's LOCAL port: accepts flits from the router's LOCAL output (`o_s2d[LOCAL].flit` / `o_downstream_req[LOCAL]`), buffers them in a small FIFO, and returns on/off flow control into the router's `i_downstream_ack[LOCAL]`. A programmable-rate drain models a slow core. A packet FSM on the drain side checks head/body/tail ordering and destination address, and maintains statistics and sticky error flags for the bench.

## Interface
- `router_conf`, default `'{xaddr:0, yaddr:0}`: node address of the attached router; HEAD destinations are checked against it.
- `FIFO_DEPTH`, default 8: flit buffer entries; power of two, ≥4.
- `OFF_THRESH`, default `FIFO_DEPTH-2`: occupancy at or above which `o_on_off` drops. Must be ≤ `FIFO_DEPTH-2` to cover in-flight flits.
- `ON_THRESH`, default 2: occupancy at or below which `o_on_off` re-rises. Must be < `OFF_THRESH`.
- `DRAIN_PERIOD`, default 1: cycles per pop opportunity; 1 means pop every cycle; must be ≥1.
- Clock and reset: one clock; reset is synchronous and active-low.
- `clk`, in, 1: clock, rising edge.
- `reset_n`, in, 1: synchronous, active-low reset.
- `i_flit`, in, `FLIT_t`: flit from router LOCAL output.
- `i_upstream_req`, in, 1: flit valid this cycle.
- `o_on_off`, out, 1: 1 means the router may send; registered.
- `o_pkt_done`, out, 1: one-cycle pulse when a TAIL or SINGLE flit is drained.
- `o_pkt_len`, out, 8: flit count of the completed packet; valid with `o_pkt_done`.
- `o_flit_count`, out, 32: total flits drained; wraps.
- `o_pkt_count`, out, 16: total packets completed; wraps.
- `o_err_overflow`, out, 1: sticky; a write occurred while the FIFO was full.
- `o_err_proto`, out, 1: sticky; flit-type ordering violation.
- `o_err_misroute`, out, 1: sticky; HEAD/SINGLE destination ≠ `router_conf`.

## Operation
- Write: on a rising edge with `i_upstream_req=1`, push `i_flit`. If the FIFO is full, drop the flit and set `o_err_overflow`. The push is not gated by `o_on_off`; the router's obedience is not assumed.
- Drain counter counts 0..`DRAIN_PERIOD-1`. A pop occurs when the counter equals `DRAIN_PERIOD-1` and the FIFO is non-empty. The counter free-runs regardless of FIFO state.
- Flow control: next `o_on_off` is set as follows.
  - 0 when occupancy after this cycle's push/pop is ≥ `OFF_THRESH`.
  - 1 when that occupancy is ≤ `ON_THRESH`.
  - Otherwise hold (hysteresis).
- Packet FSM, evaluated on each popped flit by `flit_type` (HEAD, BODY, TAIL, SINGLE):
  - IDLE, HEAD: check destination, set length=1, go to IN_PKT.
  - IDLE, SINGLE: check destination, pulse `o_pkt_done` with len=1, stay IDLE.
  - IDLE, BODY or TAIL: set `o_err_proto`, discard, stay IDLE.
  - IN_PKT, BODY: length+1; length saturates at 255.
  - IN_PKT, TAIL: length+1, pulse `o_pkt_done`, increment `o_pkt_count`, go to IDLE.
  - IN_PKT, HEAD: set `o_err_proto`, abandon the current packet, restart as a new HEAD.
  - IN_PKT, SINGLE: set `o_err_proto`, abandon the current packet, complete the SINGLE, go to IDLE.
- `o_flit_count` increments on every pop.

## Timing
- Reset values:
  - `o_on_off=1`.
  - All counters and `o_pkt_len` are 0.
  - `o_pkt_done` and all error flags are 0.
  - FIFO is empty, FSM is IDLE, drain counter is 0.
- Reset mid-operation: buffered flits and any partial packet are discarded silently; no error is raised.
- Latency: flit written at edge N is poppable at edge N+1 at the earliest (no write-to-read bypass). Its `o_pkt_done` is registered and visible after that pop edge.
- Simultaneous push and pop when full: the pop frees a slot, so the push is accepted and no overflow occurs. When empty, a push and a pop in the same cycle cannot occur.
- `o_on_off` reflects the occupancy after the current edge, i.e. one registered cycle.
- Pointers are log2(`FIFO_DEPTH`)+1 bits and wrap naturally; the extra bit separates full from empty.

## Structure
- `router_pkg` holds:
  - Already present: `FLIT_t`, `router_conf_t`, `LOCAL`.
  - To add: `flit_type_t` and `eject_state_t {EJ_IDLE, EJ_IN_PKT}`.
- Sub-module `flit_fifo` (parameterised `FIFO_DEPTH`, outputs `count`/`full`/`empty`) is reusable by router input buffers.
- The top level holds the drain counter, the on/off register, the FSM and the statistics.

## Test plan
- Reset, then a 4-flit packet HEAD(dst 0,0), BODY, BODY, TAIL at `DRAIN_PERIOD=1`: `o_pkt_done` pulses once with `o_pkt_len=4`, `o_pkt_count=1`, `o_flit_count=4`, no errors, `o_on_off` stays 1.
- `DRAIN_PERIOD=4` with back-to-back flits every cycle that obey `o_on_off`: `o_on_off` drops when occupancy reaches 6, rises when it reaches 2, and `o_err_overflow` stays 0.
- Ignore `o_on_off` and push 10 flits with no drain (large `DRAIN_PERIOD`): flits 9 and 10 are dropped and `o_err_overflow=1`.
- HEAD with dst (1,0) into a node at (0,0): `o_err_misroute=1`; the packet still completes and is counted.
- BODY while IDLE, then HEAD, HEAD, TAIL: `o_err_proto=1`, `o_pkt_count=1`, `o_pkt_len=2`.
- Assert `reset_n=0` mid-packet with 3 flits buffered: on release, occupancy 0, FSM IDLE, `o_on_off=1`, all counters 0.
